// File: rtl/disp_pkg.sv
// Shared constants, types and helpers for the signed display driver.
// Provides segment patterns, the blank code, the converter state type and pow10.
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit order gfedcba, for digits 0..9.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        if (nibble > 4'd9)
            return SEG_BLANK;
        return SEG_LUT[nibble];
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++)
            p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble converter, one magnitude bit per clock.
// Ports: clk, rst (sync, high), start, mag in; busy, done (COMMIT cycle), bcd out.
module bin2bcd_iter
    import disp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      mag,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SW = 4 * DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_sh;
    logic [SW-1:0]   w_adj;
    logic [CW-1:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = CONV;
            CONV:    if (r_cnt == CW'(1)) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == COMMIT);
    end

    // Add-3 correction on every BCD nibble >= 5 before the shift.
    always_comb begin
        w_adj = r_sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_sh[WIDTH+4*d +: 4] >= 4'd5)
                w_adj[WIDTH+4*d +: 4] = r_sh[WIDTH+4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh  <= {{(4*DIGITS){1'b0}}, mag};
                        r_cnt <= CW'(WIDTH);
                    end
                end
                CONV: begin
                    r_sh  <= w_adj << 1;
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bcd = r_sh[SW-1 -: 4*DIGITS];

endmodule

// File: rtl/signed_disp_mux.sv
// Signed value to multiplexed common-anode 7-segment display driver.
// Ports: clk, rst, value, load in; busy, seg (gfedcba, low), an (low), sig (low = neg) out.
module signed_disp_mux
    import disp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              sig
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("signed_disp_mux: WIDTH must be 2..16");
    end
    if (pow10(DIGITS) <= (64'd1 << (WIDTH - 1))) begin : g_bad_digits
        $error("signed_disp_mux: DIGITS too small for WIDTH");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("signed_disp_mux: SCAN_DIV must be >= 2");
    end

    logic                  w_busy;
    logic                  w_done;
    logic                  w_accept;
    logic [WIDTH-1:0]      w_mag;
    logic [4*DIGITS-1:0]   w_bcd;
    logic                  r_neg_pend;
    logic [4*DIGITS-1:0]   r_disp;
    logic                  r_sig;
    logic [PW-1:0]         r_pre;
    logic [IW-1:0]         r_idx;
    logic [DIGITS-1:0]     r_an;
    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     w_lz;
    logic                  w_acc;
    logic [3:0]            w_nib;
    logic                  w_blank;
    logic [6:0]            w_seg_next;

    // The most negative input negates to 2^(WIDTH-1), which still fits unsigned.
    assign w_mag    = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
    assign w_accept = load & ~w_busy;

    bin2bcd_iter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .mag   (w_mag),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_pend <= 1'b0;
            r_disp     <= '0;
            r_sig      <= 1'b1;
        end else begin
            if (w_accept)
                r_neg_pend <= value[WIDTH-1];
            if (w_done) begin
                r_disp <= w_bcd;
                r_sig  <= ~r_neg_pend;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PW'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // w_lz[i]: nibbles i..DIGITS-1 are all zero.
    always_comb begin
        w_lz  = '0;
        w_acc = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_acc   = w_acc & (r_disp[4*i +: 4] == 4'd0);
            w_lz[i] = w_acc;
        end
    end

    always_comb begin
        w_nib      = r_disp[{r_idx, 2'b00} +: 4];
        w_blank    = (r_idx != '0) && w_lz[r_idx];
        w_seg_next = w_blank ? SEG_BLANK : bcd_to_seg(w_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(DIGITS'(1) << r_idx);
            r_seg <= w_seg_next;
        end
    end

    assign busy = w_busy;
    assign seg  = r_seg;
    assign an   = r_an;
    assign sig  = r_sig;

endmodule

// File: tb/tb_signed_disp_mux.sv
// Self-checking bench for signed_disp_mux (WIDTH=8, DIGITS=3, SCAN_DIV=4).
// Decimal-arithmetic model checked every cycle plus literal display checks.
module tb_signed_disp_mux;

    localparam int W = 8;
    localparam int D = 3;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] value = '0;
    logic         load = 1'b0;
    logic         busy;
    logic [6:0]   seg;
    logic [D-1:0] an;
    logic         sig;

    int checks = 0;
    int failures = 0;

    signed_disp_mux #(
        .WIDTH    (W),
        .DIGITS   (D),
        .SCAN_DIV (S)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .busy  (busy),
        .seg   (seg),
        .an    (an),
        .sig   (sig)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected segments of digit i for a displayed magnitude m.
    function automatic logic [6:0] exp_seg(input int m, input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (i > 0 && m < p) return 7'h7F;
        return pat((m / p) % 10);
    endfunction

    function automatic int absval(input logic [W-1:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    // Model: edges since reset, one pending conversion finishing W+1 edges on.
    bit           m_on = 1'b0;
    int           m_e;
    bit           m_act;
    int           m_end;
    int           m_pend;
    bit           m_pneg;
    int           m_disp;
    logic [D-1:0] x_an;
    logic [6:0]   x_seg;
    logic         x_busy;
    logic         x_sig;

    always @(posedge clk) begin
        if (rst) begin
            m_on   <= 1'b1;
            m_e    <= 0;
            m_act  <= 1'b0;
            m_disp <= 0;
            x_an   <= '1;
            x_seg  <= 7'h7F;
            x_busy <= 1'b0;
            x_sig  <= 1'b1;
        end else if (m_on) begin
            m_e   <= m_e + 1;
            x_an  <= ~(3'(1) << ((m_e / S) % D));
            x_seg <= exp_seg(m_disp, (m_e / S) % D);
            if (m_act && m_e == m_end) begin
                m_act  <= 1'b0;
                m_disp <= m_pend;
                x_sig  <= ~m_pneg;
                x_busy <= 1'b0;
            end else if (!m_act && load) begin
                m_act  <= 1'b1;
                m_pend <= absval(value);
                m_pneg <= value[W-1];
                m_end  <= m_e + W + 1;
                x_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model_busy", int'(busy), int'(x_busy));
            chk("model_sig", int'(sig), int'(x_sig));
            chk("model_an", int'(an), int'(x_an));
            chk("model_seg", int'(seg), int'(x_seg));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_digit(input logic [D-1:0] a, input logic [6:0] s, input string nm);
        int n;
        n = 0;
        while (an !== a && n < 20) begin
            tick();
            n++;
        end
        if (an !== a) chk({nm, "_an_timeout"}, int'(an), int'(a));
        else chk(nm, int'(seg), int'(s));
    endtask

    task automatic do_load(input logic [W-1:0] v);
        int n;
        value = v;
        load  = 1'b1;
        tick();
        load = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) chk("load_done_timeout", int'(busy), 0);
        tick();
    endtask

    initial begin
        int n;
        int falls;
        logic prev;
        logic [D-1:0] segv [4];
        int seglen [4];

        // 1: reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_sig", int'(sig), 1);
        chk("rst_an", int'(an), 3'b111);
        chk("rst_seg", int'(seg), 7'h7F);
        rst = 1'b0;
        tick();
        wait_digit(3'b110, 7'b1000000, "rst_d0");
        wait_digit(3'b101, 7'h7F, "rst_d1");
        wait_digit(3'b011, 7'h7F, "rst_d2");

        // 2: value 5, busy width
        value = 8'h05;
        load  = 1'b1;
        tick();
        load = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk("busy_len", n, 9);
        tick();
        wait_digit(3'b110, 7'b0010010, "v5_d0");
        wait_digit(3'b101, 7'h7F, "v5_d1");
        wait_digit(3'b011, 7'h7F, "v5_d2");
        chk("v5_sig", int'(sig), 1);

        // 3: -13
        do_load(8'hF3);
        chk("m13_sig", int'(sig), 0);
        wait_digit(3'b110, 7'b0110000, "m13_d0");
        wait_digit(3'b101, 7'b1111001, "m13_d1");
        wait_digit(3'b011, 7'h7F, "m13_d2");

        // 4: -128 and 127
        do_load(8'h80);
        chk("m128_sig", int'(sig), 0);
        wait_digit(3'b011, 7'b1111001, "m128_d2");
        wait_digit(3'b110, 7'b0000000, "m128_d0");
        wait_digit(3'b101, 7'b0100100, "m128_d1");
        do_load(8'h7F);
        chk("p127_sig", int'(sig), 1);
        wait_digit(3'b011, 7'b1111001, "p127_d2");
        wait_digit(3'b101, 7'b0100100, "p127_d1");
        wait_digit(3'b110, 7'b1111000, "p127_d0");

        // 5: load while busy ignored, scan timing
        value = 8'h05;
        load  = 1'b1;
        tick();
        falls = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 2) begin
                value = 8'h09;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            prev = busy;
            tick();
            if (prev && !busy) falls++;
        end
        load = 1'b0;
        chk("ign_falls", falls, 1);
        wait_digit(3'b110, 7'b0010010, "ign_d0");
        wait_digit(3'b101, 7'h7F, "ign_d1");
        prev = 1'b0;
        n = 0;
        segv[0] = an;
        while (an == segv[0] && n < 20) begin
            tick();
            n++;
        end
        for (int j = 0; j < 4; j++) begin
            segv[j] = an;
            seglen[j] = 0;
            while (an == segv[j] && seglen[j] < 20) begin
                tick();
                seglen[j]++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            chk("scan_len", seglen[j], S);
            chk("scan_next", int'(segv[j+1]), int'({segv[j][1:0], segv[j][2]}));
        end

        // 6: reset mid-conversion
        value = 8'h63;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_sig", int'(sig), 1);
        tick();
        wait_digit(3'b110, 7'b1000000, "abort_d0");
        wait_digit(3'b101, 7'h7F, "abort_d1");
        do_load(8'h63);
        chk("p99_sig", int'(sig), 1);
        wait_digit(3'b110, 7'b0010000, "p99_d0");
        wait_digit(3'b101, 7'b0010000, "p99_d1");
        wait_digit(3'b011, 7'h7F, "p99_d2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_disp_mux.md
Name: signed_disp_mux

Overview:
- Parametrised successor to the 4-bit signed single-digit decoder.
- Accepts a WIDTH-bit two's-complement value and converts its magnitude to BCD iteratively (double-dabble, one bit per clock).
- Drives a DIGITS-wide multiplexed common-anode 7-segment display with leading-zero blanking, plus an active-low sign line.
- Sits between the datapath result register and the board display pins.

Parameters:
- WIDTH, 8, input value width, two's complement; legal range 2..16.
- DIGITS, 3, number of display digits; elaboration must fail unless 10^DIGITS > 2^(WIDTH-1).
- SCAN_DIV, 50000, clocks per digit refresh slot; minimum 2.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  WIDTH  signed value to display; sampled only with load.
- load  in  1  request a conversion of value.
- busy  out  1  conversion in progress; load is ignored while high.
- seg  out  7  segment drive, active-low, bit order gfedcba.
- an  out  DIGITS  digit enable, active-low, one-hot; bit 0 is the least-significant digit.
- sig  out  1  sign, active-low: 0 = negative, 1 = zero/positive.

Behaviour:
- Reset (rst high at an edge):
  - seg=7'h7F, an all ones, sig=1, busy=0.
  - Display BCD register = 0, digit index = 0, prescaler = 0, FSM = IDLE.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: load=1 captures value.
    - mag = value if the MSB is 0, else -value as an unsigned WIDTH-bit quantity; -2^(WIDTH-1) yields 2^(WIDTH-1) with no overflow.
    - neg = MSB. Clear the shift/BCD scratch register, set bit counter = WIDTH, go to CONV, busy=1.
  - CONV, one bit per clock:
    - First add 3 to every BCD nibble >= 5.
    - Then shift {bcd, mag} left by 1.
    - Decrement the counter; on the shift that takes the counter to 0, go to COMMIT.
  - COMMIT: copy scratch BCD to the display register, neg to the sign register; busy=0; go to IDLE.
- Latency: busy rises on the edge that samples load. The display register and sig take their new values, and busy falls, WIDTH+1 edges later (9 for WIDTH=8).
- Load rules:
  - load while busy is ignored; the in-flight conversion is not disturbed.
  - load in the COMMIT cycle is ignored.
  - Back-to-back accepted loads are possible every WIDTH+2 cycles.
- Display register: old contents stay on the display throughout the conversion; no partial values are ever shown.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - At wrap, digit index advances and wraps DIGITS-1 -> 0.
- Registered outputs: an, seg and sig are registered. an = ~(1<<idx). seg = pattern of the BCD nibble idx.
- Segment patterns, active-low, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles >9 are unreachable; drive 7'h7F.
- Leading-zero blanking: digit i>0 is blanked (seg=7'h7F, an bit still asserted) when nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked, so value 0 shows "0".
- Sign: zero is positive (sig=1). -0 is not possible.
- Reset mid-conversion: abort, return to reset values; no commit occurs.

Decomposition:
- Package disp_pkg:
  - SEG_BLANK = 7'h7F.
  - 10-entry segment-pattern constant array.
  - Function bcd_to_seg(nibble).
  - FSM state enum {IDLE, CONV, COMMIT}.
- Sub-module bin2bcd_iter (params WIDTH, DIGITS):
  - Owns the CONV/COMMIT sequencing.
  - Ports: clk, rst, start, mag, busy, done, bcd[4*DIGITS-1:0].
- Top level: sign capture, prescaler/scan, blanking, output registers.

Test Plan (WIDTH=8, DIGITS=3, SCAN_DIV=4):
1. Reset held 2 cycles -> busy=0, sig=1, an=3'b111/seg=7'h7F during reset. Scanning then shows digit0=1000000, digits 1–2 blanked (seg=7'h7F).
2. load with value=8'h05 -> busy high for exactly 9 cycles. Then digit0 seg=0010010, digits 1–2 blank, sig=1.
3. value=8'hF3 (-13) -> sig=0, digit0=0110000 ("3"), digit1=1111001 ("1"), digit2 blank.
4. value=8'h80 (-128) -> sig=0, digits 2/1/0 = 1111001/0100100/0000000; value=8'h7F -> sig=1, "127".
5. load 8'h05, then load 8'h09 three cycles later while busy -> second load ignored; display shows "5", busy falls once. Scan: an cycles 110 -> 101 -> 011 -> 110, each held exactly 4 clocks.
6. load 8'h63 (99), then assert rst at cycle 4 of CONV -> after reset the display shows "0", busy=0, sig=1; a subsequent load 8'h63 shows "99".
